// File: rtl/cnn_fp_pkg.sv
// Shared floating-point definitions for the small-float datapath blocks.
//   - default field widths (half precision: 5-bit exponent, 10-bit mantissa)
//   - exponent bias helper and canonical quiet-NaN builder
//   - flag bit positions within the 3-bit {overflow, underflow, inexact} word
//   - operand/result classification used to steer the packing stage
package cnn_fp_pkg;

    localparam int FP_EXP_W = 5;
    localparam int FP_MAN_W = 10;

    // Bit positions inside the flags word.
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    localparam int FP_BIAS = fp_bias(FP_EXP_W);

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
    // 0x7E00 for the default widths.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_norm_round.sv
// Normalise and round the raw mantissa product of two normal operands.
//   i_exp      : biased exponent ea+eb-BIAS, signed, EXP_W+2 bits
//   i_prod     : (2*MAN_W+2)-bit product of the two mantissas with hidden 1s
//   i_rnd_trunc: 0 = round to nearest even, 1 = truncate
//   o_exp/o_man: packed exponent and stored-mantissa fields of the result
//   o_flags    : {overflow, underflow, inexact}
// Purely combinational; the caller registers the outputs.
module fp_norm_round
    import cnn_fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic signed [EXP_W+1:0]   i_exp,
    input  logic        [2*MAN_W+1:0] i_prod,
    input  logic                      i_rnd_trunc,
    output logic        [EXP_W-1:0]   o_exp,
    output logic        [MAN_W-1:0]   o_man,
    output logic        [2:0]         o_flags
);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);

    logic                    w_msb;
    logic [MAN_W-1:0]        w_man;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_round_up;
    logic [MAN_W:0]          w_man_rnd;
    logic signed [EW-1:0]    w_exp_fin;

    // Product lies in [1,4); a set MSB means the value is >= 2 and the
    // whole field shifts down one place, so the bit selects move up by one.
    assign w_msb    = i_prod[2*MAN_W+1];
    assign w_man    = w_msb ? i_prod[2*MAN_W:MAN_W+1] : i_prod[2*MAN_W-1:MAN_W];
    assign w_guard  = w_msb ? i_prod[MAN_W]           : i_prod[MAN_W-1];
    assign w_sticky = w_msb ? (|i_prod[MAN_W-1:0])    : (|i_prod[MAN_W-2:0]);

    assign w_round_up = !i_rnd_trunc && w_guard && (w_sticky || w_man[0]);
    assign w_man_rnd  = {1'b0, w_man} + (MAN_W+1)'(w_round_up);

    // A rounding carry-out leaves the mantissa field at zero and bumps the exponent.
    assign w_exp_fin = i_exp + EW'(w_msb) + EW'(w_man_rnd[MAN_W]);

    always_comb begin
        o_exp    = w_exp_fin[EXP_W-1:0];
        o_man    = w_man_rnd[MAN_W-1:0];
        o_flags  = '0;
        o_flags[FLAG_INX] = w_guard || w_sticky;
        if (w_exp_fin <= EXP_ZERO) begin
            o_exp = '0;
            o_man = '0;
            o_flags[FLAG_UNF] = 1'b1;
            o_flags[FLAG_INX] = 1'b1;
        end else if (w_exp_fin >= EXP_TOP) begin
            o_exp = '1;
            o_man = '0;
            o_flags[FLAG_OVF] = 1'b1;
            o_flags[FLAG_INX] = 1'b1;
        end
    end

endmodule

// File: rtl/float_mult_pipe.sv
// Three-stage pipelined small-float multiplier with valid/ready handshakes.
//   S1: unpack, classify, mantissa multiply, exponent sum
//   S2: normalise + round (fp_norm_round)
//   S3: pack into the output register, applying zero/inf/NaN overrides
// Ports: clk, reset (sync, active high); in_valid/in_ready with float_a,
// float_b, rnd_mode, in_tag; out_valid/out_ready with product, out_tag,
// flags = {overflow, underflow, inexact}.
// A single enable stalls every stage together when the output is blocked.
module float_mult_pipe
    import cnn_fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   float_a,
    input  logic [EXP_W+MAN_W:0]   float_b,
    input  logic                   rnd_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   product,
    output logic [TAG_W-1:0]       out_tag,
    output logic [2:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP_W));
    localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    logic w_en;

    // ---------------- S1: unpack + multiply ----------------
    logic [EXP_W-1:0]     w_a_exp, w_b_exp;
    logic [MAN_W-1:0]     w_a_man, w_b_man;
    logic                 w_a_zero, w_b_zero, w_a_max, w_b_max;
    fp_class_e            w_class;
    logic [PW-1:0]        w_prod;
    logic signed [EW-1:0] w_exp_sum;

    assign w_a_exp  = float_a[W-2 -: EXP_W];
    assign w_b_exp  = float_b[W-2 -: EXP_W];
    assign w_a_man  = float_a[MAN_W-1:0];
    assign w_b_man  = float_b[MAN_W-1:0];
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_max  = &w_a_exp;
    assign w_b_max  = &w_b_exp;

    // An all-ones exponent takes priority over zero, so inf x 0 becomes NaN.
    always_comb begin
        w_class = CLS_NORMAL;
        if (w_a_max || w_b_max) begin
            if ((w_a_man == '0) && (w_b_man == '0) && !w_a_zero && !w_b_zero)
                w_class = CLS_INF;
            else
                w_class = CLS_NAN;
        end else if (w_a_zero || w_b_zero) begin
            w_class = CLS_ZERO;
        end
    end

    assign w_prod    = PW'({1'b1, w_a_man}) * PW'({1'b1, w_b_man});
    assign w_exp_sum = {2'b00, w_a_exp} + {2'b00, w_b_exp} - BIAS_S;

    logic                 r_s1_valid;
    logic                 r_s1_sign;
    fp_class_e            r_s1_class;
    logic [PW-1:0]        r_s1_prod;
    logic signed [EW-1:0] r_s1_exp;
    logic                 r_s1_rnd;
    logic [TAG_W-1:0]     r_s1_tag;

    // ---------------- S2: normalise + round ----------------
    logic [EXP_W-1:0]     w_nr_exp;
    logic [MAN_W-1:0]     w_nr_man;
    logic [2:0]           w_nr_flags;

    fp_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .i_exp       (r_s1_exp),
        .i_prod      (r_s1_prod),
        .i_rnd_trunc (r_s1_rnd),
        .o_exp       (w_nr_exp),
        .o_man       (w_nr_man),
        .o_flags     (w_nr_flags)
    );

    logic                 r_s2_valid;
    logic                 r_s2_sign;
    fp_class_e            r_s2_class;
    logic [EXP_W-1:0]     r_s2_exp;
    logic [MAN_W-1:0]     r_s2_man;
    logic [2:0]           r_s2_flags;
    logic [TAG_W-1:0]     r_s2_tag;

    // ---------------- S3: pack ----------------
    logic [W-1:0]         w_pack_word;
    logic [2:0]           w_pack_flags;

    always_comb begin
        w_pack_word  = {r_s2_sign, r_s2_exp, r_s2_man};
        w_pack_flags = r_s2_flags;
        case (r_s2_class)
            CLS_ZERO: begin
                w_pack_word  = {r_s2_sign, {(W-1){1'b0}}};
                w_pack_flags = '0;
            end
            CLS_INF: begin
                w_pack_word  = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_pack_flags = '0;
            end
            CLS_NAN: begin
                w_pack_word  = QNAN;
                w_pack_flags = '0;
            end
            default: ;
        endcase
    end

    logic                 r_out_valid;
    logic [W-1:0]         r_product;
    logic [TAG_W-1:0]     r_out_tag;
    logic [2:0]           r_flags;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    // Stage-valid and output registers: reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_out_tag   <= '0;
            r_flags     <= '0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_product <= w_pack_word;
                r_out_tag <= r_s2_tag;
                r_flags   <= w_pack_flags;
            end
        end
    end

    // Datapath registers only load behind a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_en && in_valid) begin
            r_s1_sign  <= float_a[W-1] ^ float_b[W-1];
            r_s1_class <= w_class;
            r_s1_prod  <= w_prod;
            r_s1_exp   <= w_exp_sum;
            r_s1_rnd   <= rnd_mode;
            r_s1_tag   <= in_tag;
        end
        if (w_en && r_s1_valid) begin
            r_s2_sign  <= r_s1_sign;
            r_s2_class <= r_s1_class;
            r_s2_exp   <= w_nr_exp;
            r_s2_man   <= w_nr_man;
            r_s2_flags <= w_nr_flags;
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign out_tag   = r_out_tag;
    assign flags     = r_flags;

endmodule

// File: tb/tb_float_mult_pipe.sv
// Self-checking bench for float_mult_pipe at default widths (half precision).
module tb_float_mult_pipe;
    localparam int TW = 4;
    localparam int NV = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   float_a = '0;
    logic [15:0]   float_b = '0;
    logic          rnd_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   product;
    logic [TW-1:0] out_tag;
    logic [2:0]    flags;

    float_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .float_a   (float_a),
        .float_b   (float_b),
        .rnd_mode  (rnd_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        rnd;
        logic [15:0] p;
        logic [2:0]  f;
    } vec_t;

    typedef struct {
        logic [15:0]   p;
        logic [2:0]    f;
        logic [TW-1:0] tag;
        int            id;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] cur_p;
    logic [2:0]  cur_f;
    int          cur_id;
    bit          toggle_en = 1'b0;

    bit            held = 1'b0;
    logic [15:0]   h_p;
    logic [2:0]    h_f;
    logic [TW-1:0] h_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Scoreboard: push on an input transfer, pop on an output transfer,
    // and require the output to hold still across a stall.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold", {9'd0, product, flags, out_tag}, {9'd0, h_p, h_f, h_t});
            end
            held = out_valid && !out_ready;
            h_p = product;
            h_f = flags;
            h_t = out_tag;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("product[%0d]", e.id), {16'd0, product}, {16'd0, e.p});
                    check($sformatf("flags[%0d]", e.id), {29'd0, flags}, {29'd0, e.f});
                    check($sformatf("tag[%0d]", e.id), {28'd0, out_tag}, {28'd0, e.tag});
                    $display("out id=%0d tag=%0d product=%h flags=%b", e.id, out_tag, product, flags);
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.p = cur_p;
                n.f = cur_f;
                n.tag = in_tag;
                n.id = cur_id;
                sb_q.push_back(n);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) out_ready = ~out_ready;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int idx, input logic [TW-1:0] tag);
        bit acc;
        float_a  = vecs[idx].a;
        float_b  = vecs[idx].b;
        rnd_mode = vecs[idx].rnd;
        in_tag   = tag;
        cur_p    = vecs[idx].p;
        cur_f    = vecs[idx].f;
        cur_id   = idx;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
        check("drain", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic latency_test(input int idx);
        int lat;
        send(idx, 4'hA);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check($sformatf("latency[%0d]", idx), lat, 32'd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          a         b         rnd   product   flags {ovf,unf,inx}
        vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4000, 3'b000};
        vecs[1]  = '{16'hC000, 16'h4200, 1'b0, 16'hC600, 3'b000};
        vecs[2]  = '{16'h3E01, 16'h3E00, 1'b0, 16'h4081, 3'b001};
        vecs[3]  = '{16'h3E01, 16'h3E00, 1'b1, 16'h4080, 3'b001};
        vecs[4]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b101};
        vecs[5]  = '{16'h0400, 16'h3800, 1'b0, 16'h0000, 3'b011};
        vecs[6]  = '{16'h8000, 16'h3C00, 1'b0, 16'h8000, 3'b000};
        vecs[7]  = '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 3'b000};
        vecs[8]  = '{16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 3'b001}; // tie, odd LSB rounds up
        vecs[9]  = '{16'h3C03, 16'h3E00, 1'b0, 16'h3E04, 3'b001}; // tie, even LSB stays
        vecs[10] = '{16'h7C00, 16'h4000, 1'b0, 16'h7C00, 3'b000};
        vecs[11] = '{16'hFC00, 16'h4000, 1'b0, 16'hFC00, 3'b000};
        vecs[12] = '{16'h7C00, 16'h3E00, 1'b0, 16'h7E00, 3'b000};
        vecs[13] = '{16'hBC00, 16'hBC00, 1'b0, 16'h3C00, 3'b000};
        vecs[14] = '{16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 3'b001};
        vecs[15] = '{16'h3FFE, 16'h3C01, 1'b0, 16'h4000, 3'b001}; // rounding carry-out
        vecs[16] = '{16'h0400, 16'h0400, 1'b0, 16'h0000, 3'b011};
        vecs[17] = '{16'h8400, 16'h0400, 1'b0, 16'h8000, 3'b011};

        // Reset state, with in_ready high throughout reset.
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_tag", {28'd0, out_tag}, 32'd0);
        check("rst_flags", {29'd0, flags}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First transfer on the first edge with reset low, then latency.
        latency_test(0);
        latency_test(1);

        // Whole table back to back with out_ready high.
        for (int i = 0; i < NV; i++) send(i, TW'(i));
        drain();

        // Streaming with out_ready toggling.
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) send(i, TW'(i));
        drain();
        toggle_en = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset with three operations in flight.
        out_ready = 1'b0;
        send(2, 4'd1);
        send(3, 4'd2);
        send(4, 4'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_product", {16'd0, product}, 32'd0);
        check("post_rst_flags", {29'd0, flags}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(13, 4'd5);
        drain();

        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/float_mult_pipe.md
FLOAT_MULT_PIPE -- requirements
Module: float_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 SHALL have port clk, input, 1, the only clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, operand pair present.
REQ-007 SHALL have port in_ready, output, 1, block accepts the operand pair this cycle.
REQ-008 SHALL have ports float_a and float_b, input, W each, IEEE-style operands.
REQ-009 SHALL have port rnd_mode, input, 1: 0 = round-to-nearest-even, 1 = truncate; captured with its operands.
REQ-010 SHALL have port in_tag, input, TAG_W, returned unchanged with the result.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and product (output, W).
REQ-012 SHALL have ports out_tag (output, TAG_W) and flags (output, 3) = {overflow, underflow, inexact}.

Function
REQ-013 SHALL transfer data only on valid && ready, on both ports.
REQ-014 SHALL be a 3-stage pipeline: S1 unpack + mantissa multiply; S2 normalise + round; S3 pack into the output register.
REQ-015 SHALL use one pipeline enable en = !out_valid || out_ready; in_ready = en; all stages advance only when en = 1.
REQ-016 SHALL, with out_ready held high, present the result 3 cycles after acceptance and sustain 1 result per cycle.
REQ-017 SHALL hold product, out_tag, flags and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-018 SHALL set the sign to a[W-1] XOR b[W-1] for every result, including zero.
REQ-019 SHALL treat an operand with exponent 0 (zero or subnormal) as zero, giving a signed-zero result with no flags set.
REQ-020 SHALL form the (2*MAN_W+2)-bit product of {1,man_a} and {1,man_b}; if the MSB is 1, shift right by 1 and add 1 to the exponent.
REQ-021 SHALL compute the biased exponent as ea+eb-BIAS (+1 from REQ-020), in signed EXP_W+2-bit arithmetic; BIAS = 2^(EXP_W-1)-1.
REQ-022 SHALL round with guard/sticky bits: RNE rounds up if G && (S || LSB); truncate drops them; a mantissa carry-out increments the exponent.
REQ-023 SHALL set inexact when any discarded bit is nonzero.
REQ-024 SHALL flush a final exponent <= 0 to signed zero and set underflow and inexact.
REQ-025 SHALL map a final exponent >= 2^EXP_W-1 to signed infinity (exponent all ones, mantissa 0) and set overflow and inexact.
REQ-026 SHALL make an all-ones-exponent operand yield infinity (both operands' mantissas 0, neither operand zero) or canonical NaN (0x7E00 at defaults) otherwise, with no flags set.

Reset
REQ-027 SHALL, on reset, clear all stage-valid bits, out_valid, product, out_tag and flags to 0 in the same edge; in-flight operations are discarded.
REQ-028 SHALL drive in_ready = 1 during and after reset; the first transfer occurs on the first edge with reset low.

Structure
REQ-029 SHALL take EXP_W/MAN_W defaults, BIAS, flag bit indices and the canonical NaN constant from the shared package cnn_fp_pkg.
REQ-030 SHALL place normalise+round (REQ-020 to REQ-025) in the sub-module fp_norm_round, a combinational block instantiated in S2.

Verification (defaults, RNE unless stated)
REQ-031 SHALL check 0x3C00 x 0x4000 -> 0x4000, 0xC000 x 0x4200 -> 0xC600, flags 0, at exactly 3 cycles latency.
REQ-032 SHALL check 0x3E01 x 0x3E00 -> 0x4081 with RNE and 0x4080 with truncate; inexact = 1 in both cases.
REQ-033 SHALL check 0x7BFF x 0x7BFF -> 0x7C00 with overflow = 1, and 0x0400 x 0x3800 -> 0x0000 with underflow = 1.
REQ-034 SHALL check 0x8000 x 0x3C00 -> 0x8000 with flags 0, and 0x7C00 x 0x0000 -> 0x7E00.
REQ-035 SHALL stream 8 back-to-back operations with tags 0-7 while out_ready toggles in a 1-0 pattern; require in-order tags, no loss or duplication, and outputs stable during stalls.
REQ-036 SHALL assert reset for one cycle with 3 operations in flight; require out_valid = 0 on the next cycle and no stale result afterwards.
